// File: rtl/fixed_to_float_pipe.sv
// rtl/fixed_to_float_pipe.sv - three-stage two's-complement integer to sign/exponent/significand float
// Build option: FTF_ROUND_EVEN_EN selects round-half-to-even; default is round-half-up.
module fixed_to_float_pipe #(
   parameter int IN_W  = 12,
   parameter int EXP_W = 3,
   parameter int MAN_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [IN_W-1:0]  in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             out_sign,
   output logic [EXP_W-1:0] out_exp,
   output logic [MAN_W-1:0] out_sig,
   output logic             out_sat
);

   // Internal exponent is wide enough for the largest pre-saturation value plus a rounding carry.
   localparam int EW_A = $clog2(IN_W + 1) + 1;
   localparam int EW   = (EW_A > EXP_W + 1) ? EW_A : EXP_W + 1;
   localparam logic [EW-1:0] EMAX = EW'((1 << EXP_W) - 1);

   logic v1, v2, v3;
   logic ld1, ld2, ld3;

   assign ld3       = !v3 || out_ready;
   assign ld2       = !v2 || ld3;
   assign ld1       = !v1 || ld2;
   assign in_ready  = ld1;
   assign out_valid = v3;

   logic            s1_sign;
   logic [IN_W-1:0] s1_mag;

   always_ff @(posedge clk) begin
      if (rst) begin
         v1      <= 1'b0;
         s1_sign <= 1'b0;
         s1_mag  <= '0;
      end else if (ld1) begin
         v1 <= in_valid;
         if (in_valid) begin
            s1_sign <= in_data[IN_W-1];
            s1_mag  <= in_data[IN_W-1] ? ('0 - in_data) : in_data;
         end
      end
   end

   int             p;
   logic [EW-1:0]  n_exp;
   logic [MAN_W-1:0] n_man;
   logic           n_guard;
`ifdef FTF_ROUND_EVEN_EN
   logic           n_sticky;
`endif

   always_comb begin
      p = 0;
      for (int i = 0; i < IN_W; i++) begin
         if (s1_mag[i]) p = i;
      end
      n_exp   = '0;
      n_man   = s1_mag[MAN_W-1:0];
      n_guard = 1'b0;
`ifdef FTF_ROUND_EVEN_EN
      n_sticky = 1'b0;
`endif
      if (p >= MAN_W) begin
         n_exp   = EW'(p - MAN_W + 1);
         n_man   = MAN_W'(s1_mag >> (p - MAN_W + 1));
         n_guard = |(s1_mag & (IN_W'(1) << (p - MAN_W)));
`ifdef FTF_ROUND_EVEN_EN
         n_sticky = |(s1_mag & ((IN_W'(1) << (p - MAN_W)) - IN_W'(1)));
`endif
      end
   end

   logic             s2_sign;
   logic [EW-1:0]    s2_exp;
   logic [MAN_W-1:0] s2_man;
   logic             s2_guard;
`ifdef FTF_ROUND_EVEN_EN
   logic             s2_sticky;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         v2       <= 1'b0;
         s2_sign  <= 1'b0;
         s2_exp   <= '0;
         s2_man   <= '0;
         s2_guard <= 1'b0;
`ifdef FTF_ROUND_EVEN_EN
         s2_sticky <= 1'b0;
`endif
      end else if (ld2) begin
         v2 <= v1;
         if (v1) begin
            s2_sign  <= s1_sign;
            s2_exp   <= n_exp;
            s2_man   <= n_man;
            s2_guard <= n_guard;
`ifdef FTF_ROUND_EVEN_EN
            s2_sticky <= n_sticky;
`endif
         end
      end
   end

   logic             rnd;
   logic [EW-1:0]    r_exp;
   logic [MAN_W-1:0] r_man;
   logic [EXP_W-1:0] f_exp;
   logic [MAN_W-1:0] f_man;
   logic             f_sat;

   always_comb begin
`ifdef FTF_ROUND_EVEN_EN
      rnd = s2_guard && (s2_sticky || s2_man[0]);
`else
      rnd = s2_guard;
`endif
      r_exp = s2_exp;
      r_man = s2_man;
      if (rnd) begin
         if (&s2_man) begin
            // Significand overflow renormalises to 1000.. and bumps the exponent.
            r_man = {1'b1, {(MAN_W-1){1'b0}}};
            r_exp = s2_exp + 1'b1;
         end else begin
            r_man = s2_man + 1'b1;
         end
      end
      f_sat = (r_exp > EMAX);
      f_exp = r_exp[EXP_W-1:0];
      f_man = r_man;
      if (f_sat) begin
         f_exp = '1;
         f_man = '1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         v3       <= 1'b0;
         out_sign <= 1'b0;
         out_exp  <= '0;
         out_sig  <= '0;
         out_sat  <= 1'b0;
      end else if (ld3) begin
         v3 <= v2;
         if (v2) begin
            out_sign <= s2_sign;
            out_exp  <= f_exp;
            out_sig  <= f_man;
            out_sat  <= f_sat;
         end
      end
   end

endmodule

// File: tb/tb_fixed_to_float_pipe.sv
// tb/tb_fixed_to_float_pipe.sv - directed self-checking bench for fixed_to_float_pipe
module tb_fixed_to_float_pipe;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [11:0] in_data = '0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic        out_sign;
   logic [2:0]  out_exp;
   logic [3:0]  out_sig;
   logic        out_sat;

   int n_checks = 0;
   int n_fail   = 0;

   fixed_to_float_pipe #(.IN_W(12), .EXP_W(3), .MAN_W(4)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_sign(out_sign), .out_exp(out_exp), .out_sig(out_sig), .out_sat(out_sat)
   );

   always #5 clk = ~clk;

   // {valid, sign, exp, sig, sat}
   wire [9:0] obs = {out_valid, out_sign, out_exp, out_sig, out_sat};

   task automatic send_word(input logic [11:0] v);
      in_valid  = 1'b1;
      in_data   = v;
      out_ready = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_data  = '0;
      @(posedge clk); #1;
   endtask

   task automatic test_reset;
      rst = 1'b1; in_valid = 1'b1; in_data = 12'd5; out_ready = 1'b1;
      @(posedge clk); #1;
      n_checks++;
      if (obs !== 10'b0) begin n_fail++; $display("FAIL reset_cyc1 got %b want %b", obs, 10'b0); end
      @(posedge clk); #1;
      n_checks++;
      if (obs !== 10'b0) begin n_fail++; $display("FAIL reset_cyc2 got %b want %b", obs, 10'b0); end
      rst = 1'b0; in_valid = 1'b0; in_data = '0;
      #1;
      n_checks++;
      if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
      @(posedge clk); #1;
      n_checks++;
      if (obs !== 10'b0) begin n_fail++; $display("FAIL reset_idle got %b want %b", obs, 10'b0); end
   endtask

   task automatic test_exact;
      logic [11:0] vals [3] = '{12'd5, 12'd24, 12'hFE0};
      logic [9:0]  want [3] = '{{1'b1, 1'b0, 3'd0, 4'b0101, 1'b0},
                                {1'b1, 1'b0, 3'd1, 4'b1100, 1'b0},
                                {1'b1, 1'b1, 3'd2, 4'b1000, 1'b0}};
      for (int i = 0; i < 3; i++) begin
         send_word(vals[i]);
         n_checks++;
         if (out_valid !== 1'b0) begin n_fail++; $display("FAIL exact_early[%0d] out_valid %b want 0", i, out_valid); end
         @(posedge clk); #1;
         n_checks++;
         if (obs !== want[i]) begin n_fail++; $display("FAIL exact[%0d] got %b want %b", i, obs, want[i]); end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_saturation;
      logic [11:0] vals [3] = '{12'd1008, 12'h7FF, 12'h800};
      logic [9:0]  want [3] = '{{1'b1, 1'b0, 3'd7, 4'b1000, 1'b0},
                                {1'b1, 1'b0, 3'd7, 4'b1111, 1'b1},
                                {1'b1, 1'b1, 3'd7, 4'b1111, 1'b1}};
      for (int i = 0; i < 3; i++) begin
         send_word(vals[i]);
         @(posedge clk); #1;
         n_checks++;
         if (obs !== want[i]) begin n_fail++; $display("FAIL sat[%0d] got %b want %b", i, obs, want[i]); end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_rounding;
      logic [11:0] vals [2] = '{12'd34, 12'd35};
`ifdef FTF_ROUND_EVEN_EN
      logic [9:0]  want [2] = '{{1'b1, 1'b0, 3'd2, 4'b1000, 1'b0},
                                {1'b1, 1'b0, 3'd2, 4'b1001, 1'b0}};
`else
      logic [9:0]  want [2] = '{{1'b1, 1'b0, 3'd2, 4'b1001, 1'b0},
                                {1'b1, 1'b0, 3'd2, 4'b1001, 1'b0}};
`endif
      for (int i = 0; i < 2; i++) begin
         send_word(vals[i]);
         @(posedge clk); #1;
         n_checks++;
         if (obs !== want[i]) begin n_fail++; $display("FAIL round[%0d] got %b want %b", i, obs, want[i]); end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_backpressure;
      int sent = 0;
      int got  = 0;
      int occ  = 0;
      logic [9:0] prev = '0;
      logic prev_stall = 1'b0;
      logic acc, xfer, want_rdy;
      logic [9:0] want;
      for (int cyc = 0; cyc < 40 && got < 6; cyc++) begin
         in_valid  = (sent < 6);
         in_data   = 12'(sent + 1);
         out_ready = !(cyc >= 4 && cyc <= 7);
         #1;
         want_rdy = !(occ == 3 && !out_ready);
         n_checks++;
         if (in_ready !== want_rdy) begin n_fail++; $display("FAIL bp_in_ready cyc %0d got %b want %b", cyc, in_ready, want_rdy); end
         if (prev_stall) begin
            n_checks++;
            if (obs !== prev) begin n_fail++; $display("FAIL bp_stable cyc %0d got %b want %b", cyc, obs, prev); end
         end
         xfer = out_valid && out_ready;
         if (xfer) begin
            want = {1'b1, 1'b0, 3'd0, 4'(got + 1), 1'b0};
            n_checks++;
            if (obs !== want) begin n_fail++; $display("FAIL bp_data[%0d] got %b want %b", got, obs, want); end
            got++;
         end
         acc = in_valid && in_ready;
         if (acc) sent++;
         occ = occ + int'(acc) - int'(xfer);
         prev = obs;
         prev_stall = out_valid && !out_ready;
         @(posedge clk); #1;
      end
      in_valid = 1'b0; out_ready = 1'b1;
      n_checks++;
      if (got != 6) begin n_fail++; $display("FAIL bp_count got %0d want 6", got); end
      @(posedge clk); #1;
      n_checks++;
      if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_dup out_valid %b want 0", out_valid); end
   endtask

   task automatic test_midreset;
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1;
         in_data  = 12'(100 * (i + 1));
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      n_checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
         n_fail++; $display("FAIL mr_full in_ready %b out_valid %b want 0 1", in_ready, out_valid);
      end
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      n_checks++;
      if (obs !== 10'b0 || in_ready !== 1'b1) begin
         n_fail++; $display("FAIL mr_after obs %b in_ready %b want 0 1", obs, in_ready);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      n_checks++;
      if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mr_stale out_valid %b want 0", out_valid); end
      send_word(12'd24);
      n_checks++;
      if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mr_early out_valid %b want 0", out_valid); end
      @(posedge clk); #1;
      n_checks++;
      if (obs !== {1'b1, 1'b0, 3'd1, 4'b1100, 1'b0}) begin
         n_fail++; $display("FAIL mr_word got %b want %b", obs, {1'b1, 1'b0, 3'd1, 4'b1100, 1'b0});
      end
      @(posedge clk); #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_exact();
      test_saturation();
      test_rounding();
      test_backpressure();
      test_midreset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
